// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-frame controller.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_EXEC,
        ST_RESP,
        ST_DONE,
        ST_ERR
    } state_t;

    // CMD byte fields: bit 7 selects write, bits 2:0 address, bits 6:3 unused.
    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_ADDR_MSB = 2;

    localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

    // Frame check byte: CMD xor DATA.
    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] data);
        return cmd ^ data;
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter. cnt holds the number of completed idle cycles
// since the last clear, so the cycle being counted is the (cnt+1)th; the
// terminal count (TIMEOUT-1 idle cycles) is therefore flagged at cnt == TIMEOUT-2.
module uart_cmd_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] cnt;

    // Count enabled cycles; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == W'(TIMEOUT - 2));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: hunts SYNC, assembles CMD/DATA/CHK, executes
// register writes or read-back requests, and owns the config register bank.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         NUM_REGS = 8,
    parameter int         TIMEOUT  = 50000,
    parameter logic [7:0] SYNC     = SYNC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_rdy,
    output logic [7:0]            tx_byte,
    output logic                  tx_req,
    input  logic                  tx_ack,
    output logic [8*NUM_REGS-1:0] cfg,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    localparam int AW = CMD_ADDR_MSB + 1;

    state_t state, state_nx;

    logic [7:0]                 cmd_q, data_q;
    logic [NUM_REGS-1:0][7:0]   regs;
    logic [AW-1:0]              addr;
    logic                       is_wr, addr_ok, chk_ok;
    logic                       in_get, tmr_en, tmr_clr, tmr_expired;

    assign addr    = cmd_q[CMD_ADDR_MSB:0];
    assign is_wr   = cmd_q[CMD_WR_BIT];
    assign addr_ok = ({1'b0, addr} < (AW+1)'(NUM_REGS));
    assign chk_ok  = (rx_byte == frame_chk(cmd_q, data_q));

    // The timer runs only while waiting on the line or the transmitter; an
    // accepted byte restarts it, a byte dropped during RESP does not.
    assign in_get  = (state == ST_GET_CMD) || (state == ST_GET_DATA) || (state == ST_GET_CHK);
    assign tmr_en  = in_get || (state == ST_RESP);
    assign tmr_clr = !tmr_en || (in_get && rx_rdy);

    uart_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; an arriving byte wins over a coincident timeout.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (rx_rdy && rx_byte == SYNC) state_nx = ST_GET_CMD;
            ST_GET_CMD:  if (rx_rdy) state_nx = ST_GET_DATA;
                         else if (tmr_expired) state_nx = ST_ERR;
            ST_GET_DATA: if (rx_rdy) state_nx = ST_GET_CHK;
                         else if (tmr_expired) state_nx = ST_ERR;
            ST_GET_CHK:  if (rx_rdy) state_nx = (chk_ok && addr_ok) ? ST_EXEC : ST_ERR;
                         else if (tmr_expired) state_nx = ST_ERR;
            ST_EXEC:     state_nx = is_wr ? ST_DONE : ST_RESP;
            ST_RESP:     if (tx_ack) state_nx = ST_DONE;
                         else if (tmr_expired) state_nx = ST_ERR;
            ST_DONE:     state_nx = ST_IDLE;
            ST_ERR:      state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Capture CMD and DATA bytes as they arrive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q  <= 8'h00;
            data_q <= 8'h00;
        end else begin
            if (state == ST_GET_CMD && rx_rdy)  cmd_q  <= rx_byte;
            if (state == ST_GET_DATA && rx_rdy) data_q <= rx_byte;
        end
    end

    // Register bank write and read-back load, both in the EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs    <= '0;
            tx_byte <= 8'h00;
        end else if (state == ST_EXEC) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr == AW'(i)) begin
                    if (is_wr)
                        regs[i] <= data_q;
                    else
                        tx_byte <= regs[i];
                end
            end
        end
    end

    // Registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_req    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_count <= 8'h00;
        end else begin
            tx_req    <= (state_nx == ST_RESP);
            frame_ok  <= (state_nx == ST_DONE);
            frame_err <= (state == ST_ERR);
            if (state == ST_ERR && err_count != 8'hFF)
                err_count <= err_count + 8'h01;
        end
    end

    assign cfg = regs;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: a frame table plus hand-built sequences
// for read handshake, timeout, back-to-back frames, saturation and reset.
module tb_uart_cmd_ctrl;

    localparam int NR = 4;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      rx_byte;
    logic            rx_rdy;
    logic [7:0]      tx_byte;
    logic            tx_req;
    logic            tx_ack;
    logic [8*NR-1:0] cfg;
    logic            frame_ok;
    logic            frame_err;
    logic [7:0]      err_count;

    uart_cmd_ctrl #(.NUM_REGS(NR), .TIMEOUT(TO), .SYNC(8'hAA)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_rdy    (rx_rdy),
        .tx_byte   (tx_byte),
        .tx_req    (tx_req),
        .tx_ack    (tx_ack),
        .cfg       (cfg),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] frame;
        logic        exp_ok;
        logic        exp_err;
        logic        exp_rd;
        logic [7:0]  exp_tx;
        logic [31:0] exp_cfg;
    } vec_t;

    vec_t vecs [8];

    int         tests = 0;
    int         fails = 0;
    int         ok_seen, err_seen, req_cyc, first;
    logic [7:0] txb;
    logic [7:0] errc_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and tally output pulses.
    task automatic tick();
        @(negedge clk);
        if (frame_ok === 1'b1)  ok_seen++;
        if (frame_err === 1'b1) err_seen++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_byte = b;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f);
        send_byte(f[31:24]);
        send_byte(f[23:16]);
        send_byte(f[15:8]);
        send_byte(f[7:0]);
    endtask

    // Run n cycles, acknowledging a pending tx_req after ack_after cycles.
    task automatic settle(input int n, input int ack_after);
        for (int c = 0; c < n; c++) begin
            if (tx_ack) tx_ack = 1'b0;
            else if (tx_req) begin
                if (req_cyc == 0) txb = tx_byte;
                req_cyc++;
                if (req_cyc == ack_after) tx_ack = 1'b1;
            end
            tick();
        end
        tx_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'hAA835CDF, 1'b1, 1'b0, 1'b0, 8'h00, 32'h5C000000};
        vecs[1] = '{32'hAA030003, 1'b1, 1'b0, 1'b1, 8'h5C, 32'h5C000000};
        vecs[2] = '{32'hAA811100, 1'b0, 1'b1, 1'b0, 8'h00, 32'h5C000000};
        vecs[3] = '{32'hAA811190, 1'b1, 1'b0, 1'b0, 8'h00, 32'h5C001100};
        vecs[4] = '{32'hAA860187, 1'b0, 1'b1, 1'b0, 8'h00, 32'h5C001100};
        vecs[5] = '{32'hAA80A525, 1'b1, 1'b0, 1'b0, 8'h00, 32'h5C0011A5};
        vecs[6] = '{32'hAA020002, 1'b1, 1'b0, 1'b1, 8'h00, 32'h5C0011A5};
        vecs[7] = '{32'hAAFA3CC6, 1'b1, 1'b0, 1'b0, 8'h00, 32'h5C3C11A5};

        rst = 1'b1; rx_byte = 8'h00; rx_rdy = 1'b0; tx_ack = 1'b0;
        ok_seen = 0; err_seen = 0; req_cyc = 0; txb = 8'h00; errc_exp = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cfg", cfg, 32'h0);
        chk("rst_tx_req", 32'(tx_req), 32'h0);
        chk("rst_tx_byte", 32'(tx_byte), 32'h0);
        chk("rst_ok", 32'(frame_ok), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        chk("rst_errc", 32'(err_count), 32'h0);
        rst = 1'b0;
        tick();

        // Frame table.
        for (int i = 0; i < 8; i++) begin
            ok_seen = 0; err_seen = 0; req_cyc = 0; txb = 8'h00;
            send_frame(vecs[i].frame);
            chk($sformatf("v%0d_n1_ok", i), 32'(frame_ok), 32'h0);
            chk($sformatf("v%0d_n1_err", i), 32'(frame_err), 32'h0);
            tick();
            if (vecs[i].exp_err) errc_exp++;
            if (vecs[i].exp_ok && !vecs[i].exp_rd) begin
                chk($sformatf("v%0d_n2_ok", i), 32'(frame_ok), 32'h1);
                chk($sformatf("v%0d_n2_cfg", i), cfg, vecs[i].exp_cfg);
            end
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d_n2_err", i), 32'(frame_err), 32'h1);
                chk($sformatf("v%0d_n2_errc", i), 32'(err_count), 32'(errc_exp));
            end
            settle(28, 10);
            chk($sformatf("v%0d_ok_cnt", i), 32'(ok_seen), 32'(vecs[i].exp_ok));
            chk($sformatf("v%0d_err_cnt", i), 32'(err_seen), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_req", i), 32'(req_cyc > 0), 32'(vecs[i].exp_rd));
            if (vecs[i].exp_rd) chk($sformatf("v%0d_tx", i), 32'(txb), 32'(vecs[i].exp_tx));
            chk($sformatf("v%0d_cfg", i), cfg, vecs[i].exp_cfg);
            chk($sformatf("v%0d_errc", i), 32'(err_count), 32'(errc_exp));
        end

        // Read handshake timing, with a SYNC byte dropped during RESP.
        ok_seen = 0; err_seen = 0;
        send_frame(32'hAA000000);
        chk("rd_n1_req", 32'(tx_req), 32'h0);
        tick();
        chk("rd_n2_req", 32'(tx_req), 32'h1);
        chk("rd_n2_byte", 32'(tx_byte), 32'hA5);
        send_byte(8'hAA);
        chk("rd_hold_req", 32'(tx_req), 32'h1);
        chk("rd_hold_ok", 32'(frame_ok), 32'h0);
        repeat (6) tick();
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk("rd_ack_req", 32'(tx_req), 32'h0);
        chk("rd_ack_ok", 32'(frame_ok), 32'h1);
        tick();
        chk("rd_ok_pulse", 32'(frame_ok), 32'h0);
        // Stray ack while idle does nothing.
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        repeat (120) tick();
        chk("rd_ok_total", 32'(ok_seen), 32'h1);
        chk("rd_drop_noerr", 32'(err_seen), 32'h0);

        // Timeout after AA 82 and silence.
        err_seen = 0; first = -1;
        send_byte(8'hAA);
        send_byte(8'h82);
        for (int i = 1; i <= 150; i++) begin
            if (frame_err === 1'b1 && first < 0) first = i;
            if (tx_req === 1'b1) chk("to_no_req", 32'(tx_req), 32'h0);
            tick();
        end
        errc_exp++;
        chk("to_latency", 32'(first), 32'd101);
        chk("to_err_cnt", 32'(err_seen), 32'h1);
        chk("to_errc", 32'(err_count), 32'(errc_exp));
        err_seen = 0;
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (120) tick();
        chk("garbage_noerr", 32'(err_seen), 32'h0);
        chk("garbage_errc", 32'(err_count), 32'(errc_exp));

        // Byte arriving on the terminal-count cycle is accepted.
        ok_seen = 0; err_seen = 0;
        send_byte(8'hAA);
        send_byte(8'h82);
        repeat (97) tick();
        send_byte(8'h07);
        send_byte(8'h85);
        repeat (5) tick();
        chk("tc_ok", 32'(ok_seen), 32'h1);
        chk("tc_noerr", 32'(err_seen), 32'h0);
        chk("tc_cfg", cfg, 32'h5C0711A5);

        // Back-to-back frames: next SYNC in the first IDLE cycle.
        ok_seen = 0; err_seen = 0;
        send_frame(32'hAA800181);
        tick();
        send_frame(32'hAA810283);
        repeat (5) tick();
        chk("b2b_ok", 32'(ok_seen), 32'h2);
        chk("b2b_cfg", cfg, 32'h5C070201);

        // Error counter saturation.
        err_seen = 0;
        for (int i = 0; i < 260; i++) begin
            send_frame(32'hAA811100);
            repeat (2) tick();
        end
        repeat (3) tick();
        chk("sat_err_cnt", 32'(err_seen), 32'd260);
        chk("sat_errc", 32'(err_count), 32'hFF);
        chk("sat_cfg", cfg, 32'h5C070201);

        // Reset mid-frame.
        ok_seen = 0; err_seen = 0;
        send_byte(8'hAA);
        send_byte(8'h83);
        rst = 1'b1;
        tick();
        chk("mrst_cfg", cfg, 32'h0);
        chk("mrst_errc", 32'(err_count), 32'h0);
        chk("mrst_tx", 32'({tx_req, tx_byte, frame_ok, frame_err}), 32'h0);
        tick();
        rst = 1'b0;
        send_byte(8'h5C);
        send_byte(8'hDF);
        repeat (10) tick();
        chk("mrst_noerr", 32'(err_seen), 32'h0);
        chk("mrst_nook", 32'(ok_seen), 32'h0);
        chk("mrst_cfg_after", cfg, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command-frame controller sitting behind the logger's UART receiver. It consumes received bytes, hunts for a sync byte, assembles 4-byte command frames, checks them, and sequences configuration-register writes or read-back requests to the UART transmitter. It owns the logger's configuration register bank and exposes it flat to the acquisition logic.

## Interface
Parameters:
- `NUM_REGS`, default 8: number of 8-bit config registers; legal range 1..8.
- `TIMEOUT`, default 50000: inter-byte timeout, in clk cycles.
- `SYNC`, default 8'hAA: frame sync byte.

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `rx_byte`  in  8: received byte; valid when `rx_rdy` is high.
- `rx_rdy`  in  1: single-cycle byte-ready pulse from the receiver.
- `tx_byte`  out  8: read-back data; stable while `tx_req` is high.
- `tx_req`  out  1: transmit request; held until acknowledged.
- `tx_ack`  in  1: transmitter accepted `tx_byte`; single-cycle pulse.
- `cfg`  out  8*NUM_REGS: register bank, flattened; reg i at `[8i+7:8i]`.
- `frame_ok`  out  1: single-cycle pulse per executed frame.
- `frame_err`  out  1: single-cycle pulse per rejected or abandoned frame.
- `err_count`  out  8: saturating count of `frame_err` pulses.

## Operation
- Frame layout: SYNC, CMD, DATA, CHK.
  - CMD[7]=1 is a write; CMD[7]=0 is a read.
  - CMD[2:0] is the address; CMD[6:3] is ignored.
  - CHK must equal CMD ^ DATA.
- State machine:
  - IDLE: byte == SYNC -> GET_CMD. Any other byte is discarded silently, with no error.
  - GET_CMD -> GET_DATA -> GET_CHK, one byte each. A SYNC value in these positions is data; there is no resync.
  - GET_CHK, on byte:
    - checksum bad, or addr >= NUM_REGS -> ERR.
    - otherwise -> EXEC.
  - EXEC, one cycle:
    - write: reg[addr] <= DATA, then -> DONE.
    - read: load `tx_byte` <= reg[addr], then -> RESP.
  - RESP: hold `tx_req`. When `tx_ack` is sampled high -> DONE.
  - DONE, one cycle: pulse `frame_ok`, -> IDLE.
  - ERR, one cycle: pulse `frame_err`, increment `err_count`, -> IDLE.
- Timeout:
  - Counter clears on every accepted `rx_rdy` and whenever in IDLE.
  - In GET_*/RESP, reaching TIMEOUT-1 -> ERR. `tx_req` drops with it.
- Bytes arriving in EXEC, RESP, DONE or ERR are dropped.
  - A drop in RESP does not abort the response or clear the timeout.
- `tx_ack` outside RESP is ignored.
- `err_count` saturates at 8'hFF.
- Reset:
  - state IDLE; all registers 8'h00; `tx_byte` 8'h00.
  - `tx_req`, `frame_ok`, `frame_err` 0; `err_count` 0.
  - Timeout counter 0.
  - Reset mid-frame abandons the frame with no `frame_err`.

## Timing
- All outputs are registered; no combinational path from an input to an output.
- CHK `rx_rdy` at cycle N:
  - EXEC at N+1.
  - Write: `cfg` updated and visible at N+2; `frame_ok` high at N+2.
  - Read: `tx_req` and `tx_byte` valid from N+2.
- `tx_ack` at cycle M (M ≥ N+2): `tx_req` low at M+1; `frame_ok` high at M+1.
- Bad CHK at N: `frame_err` high at N+2; `err_count` increments at N+2.
- Timeout: `frame_err` high 2 cycles after the terminal count.
- `rx_rdy` coincident with the terminal count: the byte wins, and the counter clears.
- Back-to-back frames: the next SYNC is accepted from the first IDLE cycle.

## Structure
- Package `uart_cmd_pkg` holds:
  - the state encoding: IDLE, GET_CMD, GET_DATA, GET_CHK, EXEC, RESP, DONE, ERR.
  - CMD bit-field constants: `CMD_WR_BIT`=7, `CMD_ADDR_MSB`=2.
  - default `SYNC`.
- Sub-module `uart_cmd_timer`: loadable timeout counter. Inputs `clr`, `en`; output `expired`; width `$clog2(TIMEOUT)`.
- The register bank stays inline in `uart_cmd_ctrl`.

## Test plan
- Write: AA, 83, 5C, DF.
  - Expect `cfg[31:24]`=5C at N+2 and one `frame_ok`.
  - Expect no `tx_req` and no `frame_err`.
- Read, after the write above: AA, 03, 00, 03.
  - Expect `tx_req` from N+2 with `tx_byte`=5C.
  - `tx_ack` after 10 cycles -> `tx_req` low next cycle, `frame_ok` pulses.
- Bad checksum: AA, 81, 11, 00.
  - Expect `frame_err` and `err_count`=1; `cfg` unchanged.
  - A following good frame executes normally.
- Timeout: AA, 82, then silence with `TIMEOUT`=100 in the bench.
  - Expect `frame_err` 101 cycles after the 82 byte.
  - Expect return to IDLE; garbage bytes 11, 22 then produce no errors.
- Out of range: with `NUM_REGS`=4, frame AA, 86, 01, 87 -> `frame_err`, no write.
- Saturation and reset:
  - 260 bad frames -> `err_count`=FF.
  - Assert `rst` mid-frame -> all outputs zero, no `frame_err`.
